// File: rtl/pmem_responder.sv
// pmem_responder: line-granular main-memory model answering cache pmem requests after DELAY cycles
//   i_clk           clock, all state changes on the rising edge
//   i_reset         synchronous active-high reset (line storage is not cleared)
//   i_pmem_address  byte address, line index = [LINE_BITS+3:4]
//   i_pmem_read     line read request, held until o_pmem_resp
//   i_pmem_write    line write request, held until o_pmem_resp
//   i_pmem_wdata    write line data
//   o_pmem_rdata    read line data, valid in the resp cycle of a read, held otherwise
//   o_pmem_resp     one-cycle completion pulse
//   o_read_count    completed reads, wraps
//   o_write_count   completed writes, wraps
//   o_protocol_err  sticky: simultaneous read+write or request dropped while busy
`timescale 1ns/1ps
module pmem_responder #(
    parameter int DELAY     = 10,
    parameter int LINE_BITS = 12
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [15:0]  i_pmem_address,
    input  logic         i_pmem_read,
    input  logic         i_pmem_write,
    input  logic [127:0] i_pmem_wdata,
    output logic [127:0] o_pmem_rdata,
    output logic         o_pmem_resp,
    output logic [15:0]  o_read_count,
    output logic [15:0]  o_write_count,
    output logic         o_protocol_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [7:0] CNT_INIT = 8'(DELAY - 1);
    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [LINE_BITS-1:0] r_idx;
    logic [127:0]         r_wdata;
    logic [127:0]         r_rdata;
    logic                 r_op_write;
    logic                 r_resp;
    logic                 r_err;
    logic [15:0]          r_read_count;
    logic [15:0]          r_write_count;
    logic [127:0]         r_mem [2**LINE_BITS];
    logic                 w_req;
    logic [LINE_BITS-1:0] w_idx;
    logic                 w_unused;
    assign w_req    = i_pmem_read | i_pmem_write;
    assign w_idx    = i_pmem_address[LINE_BITS+3:4];
    assign w_unused = ^i_pmem_address;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_resp        <= 1'b0;
            r_rdata       <= '0;
            r_read_count  <= '0;
            r_write_count <= '0;
            r_err         <= 1'b0;
        end else begin
            if (i_pmem_read && i_pmem_write)
                r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx      <= w_idx;
                        r_wdata    <= i_pmem_wdata;
                        r_op_write <= i_pmem_write;
                        // DELAY=1 skips BUSY, so the read must use the live index
                        if (DELAY == 1) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                            if (!i_pmem_write)
                                r_rdata <= r_mem[w_idx];
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end else if (r_cnt == 8'd1) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        if (!r_op_write)
                            r_rdata <= r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_resp  <= 1'b0;
                    if (r_op_write)
                        r_write_count <= r_write_count + 16'd1;
                    else
                        r_read_count <= r_read_count + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // Storage has no reset; a write commits at the edge that ends RESP unless reset aborts it
    always_ff @(posedge i_clk) begin
        if (!i_reset && r_state == RESP && r_op_write)
            r_mem[r_idx] <= r_wdata;
    end
    assign o_pmem_rdata   = r_rdata;
    assign o_pmem_resp    = r_resp;
    assign o_read_count   = r_read_count;
    assign o_write_count  = r_write_count;
    assign o_protocol_err = r_err;
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: directed bench for pmem_responder with a DELAY=4 instance (a_) and a DELAY=1 instance (b_)
//   each test task drives one scenario and checks its results inline; inputs change 1ns after
//   a rising edge and outputs are sampled on the falling edge; cycle 0 is the first request cycle
`timescale 1ns/1ps
module tb_pmem_responder;
    localparam logic [127:0] D1 = 128'hDEADBEEF_00112233_44556677_8899AABB;
    localparam logic [127:0] D2 = 128'h0F0F0F0F_11111111_22222222_33333333;
    localparam logic [127:0] D3 = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    localparam logic [127:0] D4 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D5 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] D6 = 128'h00000000_00000001_00000002_00000003;
    localparam logic [127:0] D7 = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
    localparam logic [127:0] D8 = 128'hCAFEF00D_12345678_9ABCDEF0_0BADC0DE;
    localparam logic [127:0] D9 = 128'h13579BDF_2468ACE0_FDB97531_0ECA8642;
    logic         clk = 1'b0;
    logic         a_reset, a_rd, a_wr, a_resp, a_err;
    logic [15:0]  a_addr, a_rc, a_wc;
    logic [127:0] a_wdata, a_rdata;
    logic         b_reset, b_rd, b_wr, b_resp, b_err;
    logic [15:0]  b_addr, b_rc, b_wc;
    logic [127:0] b_wdata, b_rdata;
    int passed = 0;
    int total  = 0;
    always #5 clk = ~clk;
    pmem_responder #(.DELAY(4), .LINE_BITS(12)) dut_a (
        .i_clk(clk), .i_reset(a_reset), .i_pmem_address(a_addr), .i_pmem_read(a_rd),
        .i_pmem_write(a_wr), .i_pmem_wdata(a_wdata), .o_pmem_rdata(a_rdata), .o_pmem_resp(a_resp),
        .o_read_count(a_rc), .o_write_count(a_wc), .o_protocol_err(a_err)
    );
    pmem_responder #(.DELAY(1), .LINE_BITS(12)) dut_b (
        .i_clk(clk), .i_reset(b_reset), .i_pmem_address(b_addr), .i_pmem_read(b_rd),
        .i_pmem_write(b_wr), .i_pmem_wdata(b_wdata), .o_pmem_rdata(b_rdata), .o_pmem_resp(b_resp),
        .o_read_count(b_rc), .o_write_count(b_wc), .o_protocol_err(b_err)
    );
    task automatic drive(input bit sel, input logic rd, input logic wr, input logic [15:0] addr, input logic [127:0] wd);
        if (sel) begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd;
        end
    endtask
    // Runs one request for ncyc cycles, dropping it after the first resp (unless hold) or at drop_at
    task automatic xact(input bit sel, input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, input int ncyc, input int drop_at, input bit hold,
                        output int first, output int last, output int nresp, output logic [127:0] rdat);
        logic r;
        first = -1; last = -1; nresp = 0; rdat = '0;
        drive(sel, rd, wr, addr, wd);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            r = sel ? b_resp : a_resp;
            if (r) begin
                nresp++;
                last = c;
                if (first < 0) begin
                    first = c;
                    rdat = sel ? b_rdata : a_rdata;
                end
            end
            @(posedge clk); #1;
            if (c + 1 == drop_at || (r && !hold))
                drive(sel, 1'b0, 1'b0, addr, wd);
        end
        drive(sel, 1'b0, 1'b0, addr, wd);
    endtask
    task automatic test_reset;
        a_reset = 1'b1; b_reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, '0);
        drive(1, 1'b0, 1'b0, 16'h0, '0);
        repeat (2) @(posedge clk);
        #1 a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        total++; if (a_resp !== 1'b0) $display("FAIL reset_resp: got %b want 0", a_resp); else passed++;
        total++; if (a_rdata !== 128'h0) $display("FAIL reset_rdata: got %h want 0", a_rdata); else passed++;
        total++; if (a_rc !== 16'h0) $display("FAIL reset_rc: got %h want 0", a_rc); else passed++;
        total++; if (a_wc !== 16'h0) $display("FAIL reset_wc: got %h want 0", a_wc); else passed++;
        total++; if (a_err !== 1'b0) $display("FAIL reset_err: got %b want 0", a_err); else passed++;
        total++; if (b_rc !== 16'h0 || b_wc !== 16'h0) $display("FAIL reset_b_counts: got %h/%h want 0/0", b_rc, b_wc); else passed++;
        @(posedge clk); #1;
    endtask
    task automatic test_write;
        int f, l, n;
        logic [127:0] d;
        xact(0, 1'b0, 1'b1, 16'h1230, D1, 8, 0, 0, f, l, n, d);
        total++; if (f !== 4) $display("FAIL write_latency: got %0d want 4", f); else passed++;
        total++; if (n !== 1) $display("FAIL write_resp_count: got %0d want 1", n); else passed++;
        total++; if (a_wc !== 16'd1) $display("FAIL write_wc: got %0d want 1", a_wc); else passed++;
        total++; if (a_rc !== 16'd0) $display("FAIL write_rc: got %0d want 0", a_rc); else passed++;
        total++; if (a_err !== 1'b0) $display("FAIL write_err: got %b want 0", a_err); else passed++;
    endtask
    task automatic test_read_back;
        int f, l, n;
        logic [127:0] d;
        xact(0, 1'b1, 1'b0, 16'h123C, '0, 8, 0, 0, f, l, n, d);
        total++; if (f !== 4) $display("FAIL read_latency: got %0d want 4", f); else passed++;
        total++; if (n !== 1) $display("FAIL read_resp_count: got %0d want 1", n); else passed++;
        total++; if (d !== D1) $display("FAIL read_data: got %h want %h", d, D1); else passed++;
        total++; if (a_rc !== 16'd1) $display("FAIL read_rc: got %0d want 1", a_rc); else passed++;
        @(negedge clk);
        total++; if (a_rdata !== D1) $display("FAIL rdata_hold: got %h want %h", a_rdata, D1); else passed++;
        @(posedge clk); #1;
    endtask
    task automatic test_abort;
        int f, l, n;
        logic [127:0] d;
        xact(0, 1'b0, 1'b1, 16'h0040, D2, 8, 0, 0, f, l, n, d);
        total++; if (a_wc !== 16'd2) $display("FAIL abort_setup_wc: got %0d want 2", a_wc); else passed++;
        xact(0, 1'b0, 1'b1, 16'h0040, D3, 8, 2, 0, f, l, n, d);
        total++; if (n !== 0) $display("FAIL abort_no_resp: got %0d resps want 0", n); else passed++;
        total++; if (a_err !== 1'b1) $display("FAIL abort_err: got %b want 1", a_err); else passed++;
        total++; if (a_wc !== 16'd2) $display("FAIL abort_wc: got %0d want 2", a_wc); else passed++;
        xact(0, 1'b1, 1'b0, 16'h0040, '0, 8, 0, 0, f, l, n, d);
        total++; if (d !== D2) $display("FAIL abort_readback: got %h want %h", d, D2); else passed++;
        total++; if (a_rc !== 16'd2) $display("FAIL abort_rc: got %0d want 2", a_rc); else passed++;
    endtask
    task automatic test_latch;
        int f, l, n;
        logic r;
        logic [127:0] d;
        f = -1; n = 0;
        drive(0, 1'b0, 1'b1, 16'h0100, D4);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            r = a_resp;
            if (r) begin
                n++;
                if (f < 0) f = c;
            end
            @(posedge clk); #1;
            if (r) drive(0, 1'b0, 1'b0, 16'h0, '0);
            else if (c == 0) drive(0, 1'b1, 1'b0, 16'h0200, D5);
        end
        drive(0, 1'b0, 1'b0, 16'h0, '0);
        total++; if (f !== 4 || n !== 1) $display("FAIL latch_resp: got cycle %0d count %0d want 4/1", f, n); else passed++;
        total++; if (a_wc !== 16'd3 || a_rc !== 16'd2) $display("FAIL latch_op: got wc %0d rc %0d want 3/2", a_wc, a_rc); else passed++;
        xact(0, 1'b1, 1'b0, 16'h0100, '0, 8, 0, 0, f, l, n, d);
        total++; if (d !== D4) $display("FAIL latch_data: got %h want %h", d, D4); else passed++;
        xact(0, 1'b1, 1'b0, 16'h0200, '0, 8, 0, 0, f, l, n, d);
        total++; if (d === D5) $display("FAIL latch_addr: got %h want anything else", d); else passed++;
    endtask
    task automatic test_simultaneous;
        int f, l, n;
        logic [127:0] d;
        a_reset = 1'b1;
        @(posedge clk); #1 a_reset = 1'b0;
        @(negedge clk);
        total++; if (a_err !== 1'b0 || a_wc !== 16'd0) $display("FAIL rereset: got err %b wc %0d want 0/0", a_err, a_wc); else passed++;
        @(posedge clk); #1;
        xact(0, 1'b1, 1'b1, 16'h0300, D5, 8, 0, 0, f, l, n, d);
        total++; if (f !== 4) $display("FAIL simul_latency: got %0d want 4", f); else passed++;
        total++; if (a_err !== 1'b1) $display("FAIL simul_err: got %b want 1", a_err); else passed++;
        total++; if (a_wc !== 16'd1 || a_rc !== 16'd0) $display("FAIL simul_counts: got wc %0d rc %0d want 1/0", a_wc, a_rc); else passed++;
        xact(0, 1'b1, 1'b0, 16'h0300, '0, 8, 0, 0, f, l, n, d);
        total++; if (d !== D5) $display("FAIL simul_readback: got %h want %h", d, D5); else passed++;
    endtask
    task automatic test_reset_busy;
        int f, l, n;
        logic [127:0] d;
        xact(0, 1'b0, 1'b1, 16'h0080, D6, 8, 0, 0, f, l, n, d);
        n = 0;
        drive(0, 1'b0, 1'b1, 16'h0080, D7);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_resp) n++;
            @(posedge clk); #1;
            if (c + 1 == 2) a_reset = 1'b1;
            if (c + 1 == 3) begin
                a_reset = 1'b0;
                drive(0, 1'b0, 1'b0, 16'h0, '0);
            end
        end
        total++; if (n !== 0) $display("FAIL rstbusy_no_resp: got %0d resps want 0", n); else passed++;
        @(negedge clk);
        total++; if (a_rdata !== 128'h0 || a_resp !== 1'b0) $display("FAIL rstbusy_outputs: got rdata %h resp %b want 0/0", a_rdata, a_resp); else passed++;
        total++; if (a_rc !== 16'd0 || a_wc !== 16'd0 || a_err !== 1'b0) $display("FAIL rstbusy_state: got rc %0d wc %0d err %b want 0/0/0", a_rc, a_wc, a_err); else passed++;
        @(posedge clk); #1;
        xact(0, 1'b1, 1'b0, 16'h0080, '0, 8, 0, 0, f, l, n, d);
        total++; if (d !== D6) $display("FAIL rstbusy_storage: got %h want %h", d, D6); else passed++;
    endtask
    task automatic test_back_to_back;
        int f, l, n;
        logic [127:0] d;
        xact(1, 1'b0, 1'b1, 16'h0050, D8, 4, 0, 0, f, l, n, d);
        total++; if (f !== 1 || b_wc !== 16'd1) $display("FAIL b2b_write: got cycle %0d wc %0d want 1/1", f, b_wc); else passed++;
        xact(1, 1'b1, 1'b0, 16'h0050, '0, 4, 0, 1, f, l, n, d);
        total++; if (f !== 1 || l !== 3 || n !== 2) $display("FAIL b2b_resp: got first %0d last %0d count %0d want 1/3/2", f, l, n); else passed++;
        total++; if (d !== D8) $display("FAIL b2b_data: got %h want %h", d, D8); else passed++;
        total++; if (b_rc !== 16'd2) $display("FAIL b2b_rc: got %0d want 2", b_rc); else passed++;
    endtask
    task automatic test_wrap;
        int f, l, n;
        logic [127:0] d;
        dut_b.r_read_count  = 16'hFFFF;
        dut_b.r_write_count = 16'hFFFF;
        xact(1, 1'b1, 1'b0, 16'h0050, '0, 4, 0, 0, f, l, n, d);
        total++; if (b_rc !== 16'h0000) $display("FAIL wrap_rc: got %h want 0000", b_rc); else passed++;
        total++; if (b_wc !== 16'hFFFF) $display("FAIL wrap_wc_hold: got %h want ffff", b_wc); else passed++;
        xact(1, 1'b0, 1'b1, 16'h0060, D9, 4, 0, 0, f, l, n, d);
        total++; if (b_wc !== 16'h0000 || b_err !== 1'b0) $display("FAIL wrap_wc: got %h err %b want 0000/0", b_wc, b_err); else passed++;
    endtask
    initial begin
        test_reset();
        test_write();
        test_read_back();
        test_abort();
        test_latch();
        test_simultaneous();
        test_reset_busy();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
